packet_translator: RTL and testbench
====================================

Name: packet_translator

Overview:
- Store-and-forward width converter: accepts 32-bit packet words with sop/eop/residual/bad framing and emits the same packets as 64-bit beats with the byte length (oplen) on every beat.
- Packets flagged bad are discarded entirely; drops raise a CPU interrupt pulse.
- Sits between a 32-bit ingress MAC interface and a 64-bit packet-processing pipeline on a single clock domain.

Parameters:
- INPUT_WIDTH, 32, input word width in bits; only 32 is supported.
- OUTPUT_WIDTH, 64, output beat width in bits; must equal 2*INPUT_WIDTH.
- BUF_DEPTH, 4096, data buffer depth in OUTPUT_WIDTH beats; must be a power of 2.
- DESC_DEPTH, 16, packet descriptor FIFO depth (one entry per committed packet).

Ports:
- iclk, input, 1: single clock; everything is synchronous to its rising edge.
- irst, input, 1: asynchronous, active-low reset.
- ivalid, input, 1: input word valid. No backpressure: every valid word is accepted.
- isop, input, 1: first word of a packet.
- ieop, input, 1: last word of a packet.
- iresidual, input, 2: valid bytes in the eop word; 0 means 4 bytes.
- idata, input, INPUT_WIDTH: input word. Byte order is preserved.
- ibad, input, 1: packet error, sampled on any word of the packet.
- oready, input, 1: downstream may accept a beat in the next cycle.
- ovalid, output, 1: output beat present. Every ovalid cycle is a completed transfer.
- ohalf_word_valid, output, 1: beat carries only odata[63:32]. Asserted only together with ovalid and oeop.
- osop, output, 1: first beat of a packet.
- oeop, output, 1: last beat of a packet.
- oplen, output, 14: packet length in bytes.
- odata, output, OUTPUT_WIDTH: beat data; the earlier word goes in [63:32].
- obad, output, 1: always 0, because bad packets are never forwarded.
- ocpu_interrupt, output, 1: one-cycle pulse per dropped packet.

Behaviour:
- Reset (irst=0, asynchronous): all outputs are 0; buffer pointers, descriptor FIFO, pairing register and length counter are cleared. A packet in flight on either side is lost. After release, input is ignored until the next isop.
- Ingress states:
  - IDLE: ivalid&isop starts a packet. It records the start write pointer, sets len=4 and holds the word as the high half.
  - ivalid without isop in IDLE: the word is discarded silently.
  - IN_PKT: words alternate high half / low half. A beat is written to the buffer when the low half arrives.
- Length: the eop word adds (iresidual==0 ? 4 : iresidual) bytes; other words add 4.
- A single-word packet (isop&ieop in the same word) is legal.
- Eop with an odd word count: the final beat is written with the low half zeroed and its half flag set.
- Each buffer entry stores {data, sop, eop, half}.
- Commit at eop when no error occurred: push a descriptor {len} and advance the committed write pointer. The output side sees a packet only after commit.
- Drop (rewind the write pointer to the packet start, pulse ocpu_interrupt one cycle after the eop/abort) on any of:
  - ibad seen on any word of the packet;
  - buffer full during the packet;
  - descriptor FIFO full at eop;
  - length exceeding 16383;
  - ivalid&isop while in IN_PKT, which drops the old packet and starts the new one.
- Egress:
  - oready is sampled at each rising edge. ovalid may be 1 in cycle N+1 only if oready was 1 at edge N and a committed beat is available. ovalid never follows an oready=0 sample.
  - Egress outputs are registered.
  - osop is 1 on the first beat of each packet. oplen equals the descriptor length on all beats of that packet and is 0 when ovalid=0.
  - The descriptor is popped on the eop beat.
  - odata[31:0] is 0 on half beats.
- Packets leave strictly in arrival order, with no interleaving or gaps inside a packet other than oready stalls. Beats never span two packets.
- Latency: the first beat of a packet appears no earlier than 2 cycles after its eop word.
- Simultaneous commit and pop of the descriptor FIFO in the same cycle is legal and count-neutral.
- Throughput: with oready held 1, sustained egress is 1 beat/cycle, so ingress at 1 word/cycle never overflows.
- Supported packet lengths are 1..16383 bytes; the designed operating range is 64..9216.

Test Plan:
- 64-byte good packet (16 words), oready=1 -> 8 beats; osop on beat 1, oeop on beat 8, oplen=64 on all beats, ohalf_word_valid=0, data pairs in order.
- 66-byte packet (17 words, last residual=2) -> 9 beats; beat 9 has oeop=1, ohalf_word_valid=1, odata[63:32]=word17, odata[31:0]=0; oplen=66.
- Good / bad (ibad on word 5) / good packets -> only the two good packets are output; one ocpu_interrupt pulse; obad always 0.
- Random oready (25% low) with random 64..9216-byte packets -> no ovalid in any cycle after an oready=0 sample; every word matches; oplen correct on every sop.
- oready=0 long enough to fill the buffer with 9216-byte packets -> the overflowing packet is dropped whole with an interrupt; earlier packets are intact after oready=1.
- irst asserted mid-egress -> outputs are 0 immediately; after release the next complete packet is output alone and correctly.

Source files
------------

// File: rtl/packet_translator.sv
// Store-and-forward 32-to-64-bit packet width converter with bad-packet discard.
// Packets become visible to egress only once committed at a clean eop.
module packet_translator #(
    parameter int unsigned INPUT_WIDTH  = 32,
    parameter int unsigned OUTPUT_WIDTH = 64,
    parameter int unsigned BUF_DEPTH    = 4096,
    parameter int unsigned DESC_DEPTH   = 16
) (
    input  logic                    iclk,
    input  logic                    irst,
    input  logic                    ivalid,
    input  logic                    isop,
    input  logic                    ieop,
    input  logic [1:0]              iresidual,
    input  logic [INPUT_WIDTH-1:0]  idata,
    input  logic                    ibad,
    input  logic                    oready,
    output logic                    ovalid,
    output logic                    ohalf_word_valid,
    output logic                    osop,
    output logic                    oeop,
    output logic [13:0]             oplen,
    output logic [OUTPUT_WIDTH-1:0] odata,
    output logic                    obad,
    output logic                    ocpu_interrupt
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);
    localparam int unsigned DW = $clog2(DESC_DEPTH);
    localparam int unsigned EW = OUTPUT_WIDTH + 3;
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);
    localparam logic [DW-1:0] DP_ONE    = DW'(1);
    localparam logic [DW:0]   DC_ONE    = (DW+1)'(1);
    localparam logic [DW:0]   DESC_FULL = (DW+1)'(DESC_DEPTH);
    localparam logic [14:0]   MAX_LEN   = 15'd16383;

    typedef enum logic {ST_IDLE, ST_PKT} in_state_t;

    in_state_t         state_q, state_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d, cmt_ptr_q, cmt_ptr_d, rd_ptr_q;
    logic [INPUT_WIDTH-1:0] hi_q, hi_d;
    logic              hi_vld_q, hi_vld_d, first_q, first_d, err_q, err_d;
    logic [14:0]       len_q, len_d;
    logic              intr_q;
    logic [DW-1:0]     desc_wr_q, desc_rd_q;
    logic [DW:0]       desc_cnt_q;

    logic              ovalid_q, ohalf_q, osop_q, oeop_q;
    logic [13:0]       oplen_q;
    logic [OUTPUT_WIDTH-1:0] odata_q;

    logic [EW-1:0]     buf_q [BUF_DEPTH];
    logic [13:0]       desc_q [DESC_DEPTH];

    logic              drop, push, wr_en;
    logic [EW-1:0]     wr_entry, rd_entry;
    logic [AW-1:0]     wr_addr;
    logic [AW:0]       ptr_w, used_w;
    logic              err_w, hi_w, first_w;
    logic [14:0]       len_w, add_w;
    logic              avail, take_out, pop;

    // A new sop always restarts from the committed pointer, which implicitly rewinds an aborted packet.
    always_comb begin
        state_d  = state_q;
        wr_ptr_d = wr_ptr_q;
        cmt_ptr_d = cmt_ptr_q;
        hi_d     = hi_q;
        hi_vld_d = hi_vld_q;
        first_d  = first_q;
        err_d    = err_q;
        len_d    = len_q;
        drop     = 1'b0;
        push     = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_entry = '0;
        ptr_w    = wr_ptr_q;
        err_w    = err_q;
        len_w    = len_q;
        hi_w     = hi_vld_q;
        first_w  = first_q;
        add_w    = 15'd4;
        used_w   = '0;
        if (ivalid && isop && state_q == ST_PKT)
            drop = 1'b1;
        if (ivalid && (isop || state_q == ST_PKT)) begin
            if (isop) begin
                ptr_w   = cmt_ptr_q;
                err_w   = 1'b0;
                len_w   = '0;
                hi_w    = 1'b0;
                first_w = 1'b1;
            end
            if (ieop && iresidual != 2'd0)
                add_w = {13'd0, iresidual};
            if (!err_w) begin
                len_w = len_w + add_w;
                if (len_w > MAX_LEN)
                    err_w = 1'b1;
            end
            err_w  = err_w | ibad;
            used_w = ptr_w - rd_ptr_q;
            if (hi_w || ieop) begin
                if (used_w[AW]) begin
                    err_w = 1'b1;
                end else if (!err_w) begin
                    wr_en    = 1'b1;
                    wr_addr  = ptr_w[AW-1:0];
                    wr_entry = hi_w ? {hi_q, idata, first_w, ieop, 1'b0}
                                    : {idata, {INPUT_WIDTH{1'b0}}, first_w, 1'b1, 1'b1};
                    ptr_w    = ptr_w + PTR_ONE;
                    first_w  = 1'b0;
                end
            end
            hi_d     = idata;
            hi_vld_d = !hi_w && !ieop;
            if (ieop) begin
                state_d = ST_IDLE;
                if (err_w || desc_cnt_q == DESC_FULL) begin
                    drop     = 1'b1;
                    wr_ptr_d = cmt_ptr_q;
                end else begin
                    push      = 1'b1;
                    wr_ptr_d  = ptr_w;
                    cmt_ptr_d = ptr_w;
                end
            end else begin
                state_d  = ST_PKT;
                wr_ptr_d = ptr_w;
                err_d    = err_w;
                len_d    = len_w;
                first_d  = first_w;
            end
        end
    end

    always_comb begin
        avail    = rd_ptr_q != cmt_ptr_q;
        rd_entry = buf_q[rd_ptr_q[AW-1:0]];
        take_out = oready && avail;
        pop      = take_out && rd_entry[1];
    end

    always_ff @(posedge iclk) begin
        if (wr_en)
            buf_q[wr_addr] <= wr_entry;
        if (push)
            desc_q[desc_wr_q] <= len_w[13:0];
    end

    always_ff @(posedge iclk or negedge irst) begin
        if (!irst) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            cmt_ptr_q  <= '0;
            rd_ptr_q   <= '0;
            hi_q       <= '0;
            hi_vld_q   <= 1'b0;
            first_q    <= 1'b0;
            err_q      <= 1'b0;
            len_q      <= '0;
            intr_q     <= 1'b0;
            desc_wr_q  <= '0;
            desc_rd_q  <= '0;
            desc_cnt_q <= '0;
            ovalid_q   <= 1'b0;
            ohalf_q    <= 1'b0;
            osop_q     <= 1'b0;
            oeop_q     <= 1'b0;
            oplen_q    <= '0;
            odata_q    <= '0;
        end else begin
            state_q   <= state_d;
            wr_ptr_q  <= wr_ptr_d;
            cmt_ptr_q <= cmt_ptr_d;
            hi_q      <= hi_d;
            hi_vld_q  <= hi_vld_d;
            first_q   <= first_d;
            err_q     <= err_d;
            len_q     <= len_d;
            intr_q    <= drop;
            if (push)
                desc_wr_q <= desc_wr_q + DP_ONE;
            case ({push, pop})
                2'b10:   desc_cnt_q <= desc_cnt_q + DC_ONE;
                2'b01:   desc_cnt_q <= desc_cnt_q - DC_ONE;
                default: desc_cnt_q <= desc_cnt_q;
            endcase
            if (take_out) begin
                ovalid_q <= 1'b1;
                odata_q  <= rd_entry[EW-1:3];
                osop_q   <= rd_entry[2];
                oeop_q   <= rd_entry[1];
                ohalf_q  <= rd_entry[0];
                oplen_q  <= desc_q[desc_rd_q];
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
                if (pop)
                    desc_rd_q <= desc_rd_q + DP_ONE;
            end else begin
                ovalid_q <= 1'b0;
                odata_q  <= '0;
                osop_q   <= 1'b0;
                oeop_q   <= 1'b0;
                ohalf_q  <= 1'b0;
                oplen_q  <= '0;
            end
        end
    end

    assign ovalid           = ovalid_q;
    assign ohalf_word_valid = ohalf_q;
    assign osop             = osop_q;
    assign oeop             = oeop_q;
    assign oplen            = oplen_q;
    assign odata            = odata_q;
    assign obad             = 1'b0;
    assign ocpu_interrupt   = intr_q;

endmodule

// File: tb/tb_packet_translator.sv
// Bench for packet_translator: a packet-level model queues the expected beats of
// every packet that should survive; one process compares each output cycle against it.
module tb_packet_translator;

    logic        iclk = 1'b0;
    logic        irst = 1'b0;
    logic        ivalid = 1'b0, isop = 1'b0, ieop = 1'b0, ibad = 1'b0;
    logic [1:0]  iresidual = 2'd0;
    logic [31:0] idata = '0;
    logic        oready = 1'b1;
    logic        ovalid, ohalf_word_valid, osop, oeop, obad, ocpu_interrupt;
    logic [13:0] oplen;
    logic [63:0] odata;

    packet_translator #(
        .INPUT_WIDTH(32), .OUTPUT_WIDTH(64), .BUF_DEPTH(4096), .DESC_DEPTH(16)
    ) dut (
        .iclk(iclk), .irst(irst), .ivalid(ivalid), .isop(isop), .ieop(ieop),
        .iresidual(iresidual), .idata(idata), .ibad(ibad), .oready(oready),
        .ovalid(ovalid), .ohalf_word_valid(ohalf_word_valid), .osop(osop),
        .oeop(oeop), .oplen(oplen), .odata(odata), .obad(obad),
        .ocpu_interrupt(ocpu_interrupt)
    );

    always #5 iclk = ~iclk;

    typedef struct {
        logic [63:0] data;
        logic        sop;
        logic        eop;
        logic        half;
        int          len;
    } beat_t;

    beat_t       exp_q[$];
    beat_t       e_cur;
    int          n_pass = 0, n_total = 0;
    int          intr_cnt = 0, exp_drops = 0, beat_cnt = 0;
    int          rdy_mode = 0;
    logic        rdy_s = 1'b0;
    logic [63:0] first_data = '0, last_data = '0;
    logic        last_half = 1'b0;
    int          last_len = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h, required %h", name, act, exp);
    endtask

    // oready: 0 = held high, 1 = random with 25% low, 2 = held low
    always @(negedge iclk) begin
        case (rdy_mode)
            0:       oready = 1'b1;
            1:       oready = ($urandom_range(0, 3) != 0);
            default: oready = 1'b0;
        endcase
    end

    always begin
        @(posedge iclk);
        rdy_s = oready;
        #2;
        if (irst) begin
            chk("obad", 64'(obad), 64'd0);
            if (ocpu_interrupt) intr_cnt++;
            if (!ovalid) begin
                chk("idle_oplen", 64'(oplen), 64'd0);
                chk("idle_half", 64'(ohalf_word_valid), 64'd0);
            end else begin
                beat_cnt++;
                chk("ready_rule", 64'(rdy_s), 64'd1);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(ovalid), 64'd0);
                end else begin
                    e_cur = exp_q.pop_front();
                    chk("odata", odata, e_cur.data);
                    chk("osop", 64'(osop), 64'(e_cur.sop));
                    chk("oeop", 64'(oeop), 64'(e_cur.eop));
                    chk("ohalf", 64'(ohalf_word_valid), 64'(e_cur.half));
                    chk("oplen", 64'(oplen), 64'(e_cur.len));
                end
                if (osop) first_data = odata;
                if (oeop) begin
                    last_data = odata;
                    last_half = ohalf_word_valid;
                    last_len  = int'(oplen);
                end
            end
        end
    end

    task automatic send_pkt(input int nbytes, input int bad_word, input bit exp_drop,
                            input logic [31:0] base, input bit rnd);
        int          nw;
        logic [31:0] w[];
        beat_t       b;
        nw = (nbytes + 3) / 4;
        w  = new[nw];
        for (int i = 0; i < nw; i++) w[i] = rnd ? $urandom : base + 32'(i);
        for (int i = 0; i < nw; i++) begin
            @(negedge iclk);
            ivalid    = 1'b1;
            isop      = (i == 0);
            ieop      = (i == nw - 1);
            iresidual = (i == nw - 1) ? 2'(nbytes % 4) : 2'd0;
            idata     = w[i];
            ibad      = (i == bad_word);
        end
        if (bad_word >= 0 || exp_drop) begin
            exp_drops++;
        end else begin
            for (int k = 0; k < nw; k += 2) begin
                b.sop  = (k == 0);
                b.eop  = (k + 2 >= nw);
                b.half = (k + 1 >= nw);
                b.data = b.half ? {w[k], 32'h0} : {w[k], w[k+1]};
                b.len  = nbytes;
                exp_q.push_back(b);
            end
        end
        @(negedge iclk);
        ivalid = 1'b0; isop = 1'b0; ieop = 1'b0; ibad = 1'b0;
        idata = '0; iresidual = 2'd0;
    endtask

    task automatic stray_word(input logic [31:0] d);
        @(negedge iclk);
        ivalid = 1'b1; idata = d;
        @(negedge iclk);
        ivalid = 1'b0; idata = '0;
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge iclk);
            n++;
        end
        repeat (4) @(negedge iclk);
        chk(name, 64'(exp_q.size()), 64'd0);
        chk({name, "_intr"}, 64'(intr_cnt), 64'(exp_drops));
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout, required completion");
        $fatal(1, "timeout");
    end

    initial begin
        int b0;
        int n;

        repeat (3) @(negedge iclk);
        chk("rst_ovalid", 64'(ovalid), 64'd0);
        chk("rst_odata", odata, 64'd0);
        chk("rst_oplen", 64'(oplen), 64'd0);
        chk("rst_intr", 64'(ocpu_interrupt), 64'd0);
        irst = 1'b1;
        repeat (2) @(negedge iclk);
        stray_word(32'hDEAD_BEEF);

        b0 = beat_cnt;
        send_pkt(64, -1, 1'b0, 32'hA000_0000, 1'b0);
        drain("t1_drain");
        chk("t1_beats", 64'(beat_cnt - b0), 64'd8);
        chk("t1_first", first_data, 64'hA000_0000_A000_0001);
        chk("t1_last", last_data, 64'hA000_000E_A000_000F);
        chk("t1_len", 64'(last_len), 64'd64);
        chk("t1_half", 64'(last_half), 64'd0);

        b0 = beat_cnt;
        send_pkt(66, -1, 1'b0, 32'hB000_0000, 1'b0);
        drain("t2_drain");
        chk("t2_beats", 64'(beat_cnt - b0), 64'd9);
        chk("t2_last", last_data, 64'hB000_0010_0000_0000);
        chk("t2_half", 64'(last_half), 64'd1);
        chk("t2_len", 64'(last_len), 64'd66);

        b0 = beat_cnt;
        send_pkt(64, -1, 1'b0, 32'hC000_0000, 1'b0);
        send_pkt(64, 4, 1'b0, 32'hCC00_0000, 1'b0);
        send_pkt(64, -1, 1'b0, 32'hD000_0000, 1'b0);
        drain("t3_drain");
        chk("t3_beats", 64'(beat_cnt - b0), 64'd16);
        chk("t3_intr", 64'(intr_cnt), 64'd1);

        rdy_mode = 1;
        for (int p = 0; p < 6; p++)
            send_pkt(int'($urandom_range(64, 9216)), -1, 1'b0, 32'h0, 1'b1);
        drain("t4_drain");
        rdy_mode = 0;

        rdy_mode = 2;
        repeat (3) @(negedge iclk);
        b0 = beat_cnt;
        for (int p = 0; p < 4; p++)
            send_pkt(9216, -1, (p == 3), 32'(p + 1) << 24, 1'b0);
        repeat (4) @(negedge iclk);
        chk("t5_intr", 64'(intr_cnt), 64'(exp_drops));
        chk("t5_hold", 64'(beat_cnt - b0), 64'd0);
        rdy_mode = 0;
        drain("t5_drain");
        chk("t5_beats", 64'(beat_cnt - b0), 64'd3456);

        send_pkt(64, -1, 1'b0, 32'hE000_0000, 1'b0);
        b0 = beat_cnt;
        n = 0;
        while (beat_cnt - b0 < 3 && n < 50) begin
            @(negedge iclk);
            n++;
        end
        chk("t6_midflight", 64'(beat_cnt - b0 >= 3), 64'd1);
        irst = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_ovalid", 64'(ovalid), 64'd0);
        chk("t6_rst_odata", odata, 64'd0);
        chk("t6_rst_oplen", 64'(oplen), 64'd0);
        chk("t6_rst_osop", 64'(osop), 64'd0);
        chk("t6_rst_oeop", 64'(oeop), 64'd0);
        @(negedge iclk);
        irst = 1'b1;
        repeat (2) @(negedge iclk);
        stray_word(32'h1234_5678);
        b0 = beat_cnt;
        send_pkt(69, -1, 1'b0, 32'hF000_0000, 1'b0);
        drain("t6_drain");
        chk("t6_beats", 64'(beat_cnt - b0), 64'd9);
        chk("t6_first", first_data, 64'hF000_0000_F000_0001);
        chk("t6_last", last_data, 64'hF000_0010_F000_0011);
        chk("t6_len", 64'(last_len), 64'd69);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
